io_intr_memory: RTL and testbench
=================================

# io_intr_memory

Parametrised memory-mapped I/O block for the pipelined MIPS datapath. It provides a byte-addressed, big-endian scratch memory with word access. It also contains N_CH programmable countdown timers that raise interrupts. A synchronous io_intr/intr_ack handshake hands the lowest-numbered pending channel to the CPU's ISR entry logic. It replaces the fixed 4096x8 I/O memory and its one-shot pseudo-interrupt.

## Interface
- ADDR_W, 12, byte-address width; memory holds 2^ADDR_W bytes
- DATA_W, 32, data bus width; multiple of 8; BYTES = DATA_W/8
- N_CH, 4, timer/interrupt channels (1..16)
- TIMER_W, 16, timer counter width (≤ DATA_W)
- CTRL_BASE, 12'hF00, byte address of the control window
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- io_cs  in  1  chip select
- io_wr  in  1  write strobe; write requires io_cs & io_wr
- io_rd  in  1  read strobe; read requires io_cs & io_rd
- Address  in  ADDR_W  byte address
- D_In  in  DATA_W  write data
- D_Out  out  DATA_W  read data; 'Z when not reading
- intr_ack  in  1  CPU interrupt acknowledge (level, held until io_intr drops)
- io_intr  out  1  interrupt request
- intr_id  out  max(1,$clog2(N_CH))  channel being requested

## Operation
- Control window: Address in [CTRL_BASE, CTRL_BASE + 2·N_CH·BYTES) and BYTES-aligned. Every other address is plain memory.
- Control window slots are not backed by memory.
- Memory writes are synchronous: bytes Address..Address+BYTES-1 ← D_In, MSB byte first.
- Memory reads are asynchronous and use the same byte order.
- Byte index wraps modulo 2^ADDR_W. Memory contents are not reset.
- Channel c RELOAD register at CTRL_BASE + 2c·BYTES.
  - A write stores reload and loads count.
  - Both take D_In[TIMER_W-1:0]. Reads return count, zero-extended.
- Channel c CSR register at CTRL_BASE + (2c+1)·BYTES.
  - bit0 EN (R/W), bit1 PERIODIC (R/W), bit2 PEND (R; write 1 clears).
  - All other bits read 0.
- Timer: when EN=1 and count≠0, count decrements once per cycle.
- Terminal event is the 1→0 decrement. It sets PEND.
  - If PERIODIC=1, count ← reload; else EN ← 0.
- EN=1 with count=0 does nothing.
- Interrupt FSM:
  - IDLE: if any PEND, latch intr_id = lowest pending index, set io_intr=1 → ASSERT.
  - ASSERT: on ack edge (intr_ack=1 and registered ack_q=0), clear PEND[intr_id], io_intr=0 → RELEASE.
  - RELEASE: when intr_ack=0 → IDLE.
- intr_id is stable while io_intr=1. The CPU may W1C the PEND bit of the requesting channel while in ASSERT; io_intr stays high until the ack edge.
- Priority rules:
  - A terminal event beats a same-cycle W1C or ack clear, so PEND stays 1.
  - A CSR write of EN/PERIODIC beats a same-cycle terminal-event update of EN.
  - A RELOAD write beats a same-cycle decrement or reload.
- Reset, asynchronous and immediate even mid-handshake:
  - io_intr=0, intr_id=0, FSM=IDLE, ack_q=0.
  - All count, reload and CSR bits = 0.
  - D_Out follows the combinational rule.

## Timing
- Write latency is one edge; a read in the following cycle sees the new data.
- Read latency is combinational. Reads of count show the live value.
- RELOAD=R written at edge k, then EN=1 written at edge k+1:
  - first decrement at edge k+2;
  - PEND=1 after edge k+1+R;
  - io_intr=1 after edge k+2+R.
- Ack is sampled at edge j: io_intr=0 and PEND cleared after edge j. The FSM can reassert no earlier than one cycle after intr_ack is seen low.
- Periodic channel with reload R: terminal events occur every R cycles. Reload 0 stops the timer at 0.

## Structure
- Package io_mem_pkg holds:
  - CSR bit indices: EN=0, PERIODIC=1, PEND=2;
  - FSM state enum: IDLE, ASSERT, RELEASE;
  - register offset constants: RELOAD=0, CSR=1 (in words).
- Sub-module io_timer_ch holds count, reload, EN, PERIODIC and PEND for one channel. It takes decoded write strobes, W1C strobes and ack-clear strobes. It is instantiated N_CH times via generate.
- The top level holds the address decode, byte memory, read mux and handshake FSM.

## Test plan
- After reset: write 32'h11223344 to 12'h010, read 12'h010 → 32'h11223344, Memory[12'h010]=8'h11; read 12'h012 → 32'h3344xxxx. With io_rd=0, D_Out = Z.
- Wrap: write 32'hAABBCCDD at 12'hFFE (outside the window: set CTRL_BASE=12'h800 for this test), read back at the same address → 32'hAABBCCDD; Memory[12'h000]=8'hCC.
- One-shot channel 0: RELOAD=5, CSR=1 → PEND after 5 decrements, io_intr=1 one cycle later with intr_id=0. EN reads 0. Count holds 0.
- Priority and handshake: ch1 and ch3 both pending → intr_id=1. Ack → io_intr falls, PEND1=0. Release, then one cycle later io_intr=1 with intr_id=3.
- Periodic channel 2: reload 3 → PEND set every 3 cycles. A terminal event on the same edge as a W1C of PEND leaves PEND=1.
- Assert rst while io_intr=1 and the timers are running → io_intr=0, all CSRs 0, no reassert after rst deasserts.

Source files
------------

// File: rtl/io_intr_memory_pkg.sv
// Shared definitions for the memory-mapped I/O block: CSR bit positions,
// control-window register offsets and the interrupt handshake states.
package io_mem_pkg;

  localparam int CSR_EN       = 0;
  localparam int CSR_PERIODIC = 1;
  localparam int CSR_PEND     = 2;

  // Register offsets inside a channel's two-word slot, in words.
  localparam int REG_RELOAD = 0;
  localparam int REG_CSR    = 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } intr_state_e;

  function automatic int id_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/io_intr_memory_if.sv
// CPU-side bus and interrupt handshake of io_intr_memory; the CPU is the
// master, the I/O block the slave.
interface io_intr_memory_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int N_CH   = 4
);
  localparam int ID_W = io_mem_pkg::id_width(N_CH);

  logic              io_cs;
  logic              io_wr;
  logic              io_rd;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] D_In;
  logic [DATA_W-1:0] D_Out;
  logic              intr_ack;
  logic              io_intr;
  logic [ID_W-1:0]   intr_id;

  modport master (
    output io_cs, io_wr, io_rd, Address, D_In, intr_ack,
    input  D_Out, io_intr, intr_id
  );

  modport slave (
    input  io_cs, io_wr, io_rd, Address, D_In, intr_ack,
    output D_Out, io_intr, intr_id
  );

endinterface

// File: rtl/io_intr_memory_timer_ch.sv
// One countdown timer channel: count/reload registers plus EN, PERIODIC and
// the sticky PEND flag raised on the 1->0 terminal decrement.
module io_timer_ch
  import io_mem_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reload_we_i,
  input  logic               csr_we_i,
  input  logic               ack_clr_i,
  input  logic [TIMER_W-1:0] reload_data_i,
  input  logic [2:0]         csr_data_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               en_o,
  output logic               periodic_o,
  output logic               pend_o
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic               pend_q, pend_d;
  logic               running, terminal;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    running    = en_q && (count_q != '0);
    terminal   = running && (count_q == TIMER_W'(1)) && !reload_we_i;
    count_d    = count_q;
    reload_d   = reload_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    pend_d     = pend_q;

    // A RELOAD write overrides whatever the countdown would have done.
    if (reload_we_i) begin
      count_d  = reload_data_i;
      reload_d = reload_data_i;
    end else if (running) begin
      count_d = (terminal && periodic_q) ? reload_q : count_q - TIMER_W'(1);
    end

    if (csr_we_i) begin
      en_d       = csr_data_i[CSR_EN];
      periodic_d = csr_data_i[CSR_PERIODIC];
    end else if (terminal && !periodic_q) begin
      en_d = 1'b0;
    end

    if (terminal) begin
      pend_d = 1'b1;
    end else if ((csr_we_i && csr_data_i[CSR_PEND]) || ack_clr_i) begin
      pend_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      reload_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pend_q     <= pend_d;
    end
  end

  assign count_o    = count_q;
  assign en_o       = en_q;
  assign periodic_o = periodic_q;
  assign pend_o     = pend_q;

endmodule

// File: rtl/io_intr_memory.sv
// Big-endian byte scratch memory with a control window of N_CH countdown
// timers, and the io_intr/intr_ack handshake presenting the lowest pending channel.
module io_intr_memory
  import io_mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 32,
  parameter int          N_CH      = 4,
  parameter int          TIMER_W   = 16,
  parameter int unsigned CTRL_BASE = 'hF00
) (
  input logic              clk,
  input logic              rst,
  io_intr_memory_if.slave  bus
);

  localparam int BYTES     = DATA_W / 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int ID_W      = id_width(N_CH);
  localparam int WIN_BYTES = 2 * N_CH * BYTES;

  logic              wr_en, rd_en, in_win, reg_is_csr;
  logic [31:0]       offset, word, ch_sel;
  logic [DATA_W-1:0] rd_data;

  logic [N_CH-1:0]    reload_we, csr_we, ack_clr, en, periodic, pend;
  logic [TIMER_W-1:0] count [N_CH];

  intr_state_e     state_q;
  logic            ack_q, io_intr_q, ack_edge;
  logic [ID_W-1:0] intr_id_q, low_id;

  logic [7:0] mem_q [DEPTH];

  assign wr_en = bus.io_cs && bus.io_wr;
  assign rd_en = bus.io_cs && bus.io_rd;

  // Addresses below CTRL_BASE wrap to a huge offset and fall outside the window.
  assign offset     = 32'(bus.Address) - 32'(CTRL_BASE);
  assign in_win     = (offset < 32'(WIN_BYTES)) && ((offset % 32'(BYTES)) == '0);
  assign word       = offset / 32'(BYTES);
  assign ch_sel     = word >> 1;
  assign reg_is_csr = (word[0] == REG_CSR[0]);
  assign ack_edge   = (state_q == ASSERT) && bus.intr_ack && !ack_q;

  always_comb begin
    reload_we = '0;
    csr_we    = '0;
    ack_clr   = '0;
    low_id    = '0;
    for (int c = 0; c < N_CH; c++) begin
      reload_we[c] = wr_en && in_win && (ch_sel == 32'(c)) && !reg_is_csr;
      csr_we[c]    = wr_en && in_win && (ch_sel == 32'(c)) && reg_is_csr;
      ack_clr[c]   = ack_edge && (intr_id_q == ID_W'(c));
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pend[c]) low_id = ID_W'(c);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    io_timer_ch #(.TIMER_W(TIMER_W)) u_ch (
      .clk           (clk),
      .rst           (rst),
      .reload_we_i   (reload_we[c]),
      .csr_we_i      (csr_we[c]),
      .ack_clr_i     (ack_clr[c]),
      .reload_data_i (bus.D_In[TIMER_W-1:0]),
      .csr_data_i    (bus.D_In[2:0]),
      .count_o       (count[c]),
      .en_o          (en[c]),
      .periodic_o    (periodic[c]),
      .pend_o        (pend[c])
    );
  end

  // NOTE: the byte array has no reset; clearing it would cost a reset fan-out to every cell.
  always_ff @(posedge clk) begin
    if (wr_en && !in_win) begin
      for (int b = 0; b < BYTES; b++) begin
        mem_q[bus.Address + ADDR_W'(b)] <= bus.D_In[DATA_W-1-8*b -: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_win) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_sel == 32'(c)) begin
          if (reg_is_csr) begin
            rd_data[CSR_EN]       = en[c];
            rd_data[CSR_PERIODIC] = periodic[c];
            rd_data[CSR_PEND]     = pend[c];
          end else begin
            rd_data[TIMER_W-1:0] = count[c];
          end
        end
      end
    end else begin
      for (int b = 0; b < BYTES; b++) begin
        rd_data[DATA_W-1-8*b -: 8] = mem_q[bus.Address + ADDR_W'(b)];
      end
    end
  end

  assign bus.D_Out = rd_en ? rd_data : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      io_intr_q <= 1'b0;
      intr_id_q <= '0;
    end else begin
      ack_q <= bus.intr_ack;
      case (state_q)
        IDLE: if (|pend) begin
          intr_id_q <= low_id;
          io_intr_q <= 1'b1;
          state_q   <= ASSERT;
        end
        ASSERT: if (ack_edge) begin
          io_intr_q <= 1'b0;
          state_q   <= RELEASE;
        end
        RELEASE: if (!bus.intr_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.io_intr = io_intr_q;
  assign bus.intr_id = intr_id_q;

endmodule

// File: tb/tb_io_intr_memory.sv
// Self-checking bench for io_intr_memory: scoreboarded register/memory reads
// and interrupt ids, one task per scenario.
module tb_io_intr_memory;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
    logic [31:0] mask;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rd_exp_t    sb[$];
  logic [1:0] intr_q[$];

  io_intr_memory_if #(.ADDR_W(12), .DATA_W(32), .N_CH(4)) bus ();

  io_intr_memory #(
    .ADDR_W(12), .DATA_W(32), .N_CH(4), .TIMER_W(16), .CTRL_BASE('hF00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] reload_a(input int c);
    return 12'(32'hF00 + 8 * c);
  endfunction

  function automatic logic [11:0] csr_a(input int c);
    return 12'(32'hF04 + 8 * c);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    bus.io_cs = 1'b1; bus.io_wr = 1'b1; bus.Address = a; bus.D_In = d;
    @(posedge clk);
    #1;
    bus.io_cs = 1'b0; bus.io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    bus.io_cs = 1'b1; bus.io_rd = 1'b1; bus.Address = a;
    #1;
    d = bus.D_Out;
    bus.io_cs = 1'b0; bus.io_rd = 1'b0;
  endtask

  task automatic push(input string n, input logic [11:0] a, input logic [31:0] e,
                      input logic [31:0] m = 32'hFFFF_FFFF);
    rd_exp_t x;
    x.name = n; x.addr = a; x.exp = e; x.mask = m;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    rd_exp_t     e;
    logic [31:0] got;
    #1;
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL reset_io_intr: got %b want 0", bus.io_intr);
    end
    checks++;
    if (bus.intr_id !== 2'd0) begin
      errors++; $display("FAIL reset_intr_id: got %0d want 0", bus.intr_id);
    end
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      push($sformatf("reset_count%0d", c), reload_a(c), 32'h0);
      push($sformatf("reset_csr%0d", c), csr_a(c), 32'h0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
  endtask

  task automatic test_memory;
    rd_exp_t     e;
    logic [31:0] got;
    bus_wr(12'h010, 32'h1122_3344);
    push("mem_word", 12'h010, 32'h1122_3344);
    push("mem_msb_byte", 12'h00D, 32'h0000_0011, 32'h0000_00FF);
    push("mem_unaligned", 12'h012, 32'h3344_0000, 32'hFFFF_0000);
    bus_wr(12'hFFE, 32'hAABB_CCDD);
    push("wrap_word", 12'hFFE, 32'hAABB_CCDD);
    push("wrap_low", 12'h000, 32'hCCDD_0000, 32'hFFFF_0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    bus.Address = 12'h010; bus.io_cs = 1'b1; bus.io_rd = 1'b0;
    #1;
    checks++;
    if (bus.D_Out === 32'h1122_3344) begin
      errors++; $display("FAIL dout_no_rd: got %h want released bus", bus.D_Out);
    end
    bus.io_cs = 1'b0; bus.io_rd = 1'b1;
    #1;
    checks++;
    if (bus.D_Out === 32'h1122_3344) begin
      errors++; $display("FAIL dout_no_cs: got %h want released bus", bus.D_Out);
    end
    bus.io_rd = 1'b0;
  endtask

  task automatic test_oneshot;
    rd_exp_t     e;
    logic [31:0] got;
    bus_wr(reload_a(0), 32'd5);
    bus_wr(csr_a(0), 32'h1);
    push("os_count_start", reload_a(0), 32'd5);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    tick(4);
    push("os_count_1", reload_a(0), 32'd1);
    push("os_csr_running", csr_a(0), 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    tick(1);
    push("os_count_0", reload_a(0), 32'd0);
    push("os_csr_pend", csr_a(0), 32'h4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL os_intr_early: got %b want 0", bus.io_intr);
    end
    intr_q.push_back(2'd0);
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b1) begin
      errors++; $display("FAIL os_intr_rise: got %b want 1", bus.io_intr);
    end
    checks++;
    if (bus.intr_id !== intr_q[0]) begin
      errors++; $display("FAIL os_intr_id: got %0d want %0d", bus.intr_id, intr_q[0]);
    end
    void'(intr_q.pop_front());
    bus.intr_ack = 1'b1;
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL os_intr_after_ack: got %b want 0", bus.io_intr);
    end
    bus.intr_ack = 1'b0;
    tick(3);
    push("os_csr_acked", csr_a(0), 32'h0);
    push("os_count_holds", reload_a(0), 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
  endtask

  task automatic test_periodic;
    rd_exp_t     e;
    logic [31:0] got;
    bus_wr(reload_a(2), 32'd3);
    bus_wr(csr_a(2), 32'h3);
    tick(3);
    push("per_first_pend", csr_a(2), 32'h7);
    push("per_reloaded", reload_a(2), 32'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    intr_q.push_back(2'd2);
    bus_wr(csr_a(2), 32'h7);
    checks++;
    if (bus.io_intr !== 1'b1 || bus.intr_id !== intr_q[0]) begin
      errors++; $display("FAIL per_intr: got intr=%b id=%0d want intr=1 id=%0d",
                         bus.io_intr, bus.intr_id, intr_q[0]);
    end
    void'(intr_q.pop_front());
    push("per_w1c", csr_a(2), 32'h3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    tick(1);
    bus_wr(csr_a(2), 32'h7);
    push("per_terminal_beats_w1c", csr_a(2), 32'h7);
    push("per_second_reload", reload_a(2), 32'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    bus_wr(csr_a(2), 32'h4);
    push("per_disabled", csr_a(2), 32'h0);
    push("per_count_frozen", reload_a(2), 32'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    tick(3);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL per_no_reassert: got %b want 0", bus.io_intr);
    end
  endtask

  task automatic test_priority;
    rd_exp_t     e;
    logic [31:0] got;
    int          budget;
    bus_wr(reload_a(1), 32'd5);
    bus_wr(reload_a(3), 32'd5);
    bus_wr(csr_a(1), 32'h1);
    bus_wr(csr_a(3), 32'h1);
    intr_q.push_back(2'd1);
    intr_q.push_back(2'd3);
    budget = 20;
    while (bus.io_intr !== 1'b1 && budget > 0) begin
      tick(1); budget--;
    end
    checks++;
    if (bus.io_intr !== 1'b1) begin
      errors++; $display("FAIL pri_timeout: io_intr=%b want 1 within 20 cycles", bus.io_intr);
    end
    checks++;
    if (bus.intr_id !== intr_q[0]) begin
      errors++; $display("FAIL pri_first_id: got %0d want %0d", bus.intr_id, intr_q[0]);
    end
    void'(intr_q.pop_front());
    push("pri_pend1", csr_a(1), 32'h4);
    push("pri_pend3", csr_a(3), 32'h4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    bus.intr_ack = 1'b1;
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL pri_ack_drop: got %b want 0", bus.io_intr);
    end
    push("pri_pend1_cleared", csr_a(1), 32'h0);
    push("pri_pend3_kept", csr_a(3), 32'h4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL pri_ack_held: got %b want 0", bus.io_intr);
    end
    bus.intr_ack = 1'b0;
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL pri_release_gap: got %b want 0", bus.io_intr);
    end
    tick(1);
    checks++;
    if (bus.io_intr !== 1'b1 || bus.intr_id !== intr_q[0]) begin
      errors++; $display("FAIL pri_second: got intr=%b id=%0d want intr=1 id=%0d",
                         bus.io_intr, bus.intr_id, intr_q[0]);
    end
    void'(intr_q.pop_front());
    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    tick(2);
    push("pri_pend3_cleared", csr_a(3), 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
  endtask

  task automatic test_reset_midflight;
    rd_exp_t     e;
    logic [31:0] got;
    int          budget;
    bus_wr(reload_a(1), 32'd2);
    bus_wr(csr_a(1), 32'h3);
    bus_wr(reload_a(0), 32'd9);
    bus_wr(csr_a(0), 32'h3);
    budget = 20;
    while (bus.io_intr !== 1'b1 && budget > 0) begin
      tick(1); budget--;
    end
    checks++;
    if (bus.io_intr !== 1'b1 || bus.intr_id !== 2'd1) begin
      errors++; $display("FAIL rst_pre_intr: got intr=%b id=%0d want intr=1 id=1",
                         bus.io_intr, bus.intr_id);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.io_intr !== 1'b0 || bus.intr_id !== 2'd0) begin
      errors++; $display("FAIL rst_async: got intr=%b id=%0d want intr=0 id=0",
                         bus.io_intr, bus.intr_id);
    end
    #1 rst = 1'b0;
    tick(1);
    for (int c = 0; c < 4; c++) begin
      push($sformatf("rst_count%0d", c), reload_a(c), 32'h0);
      push($sformatf("rst_csr%0d", c), csr_a(c), 32'h0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus_rd(e.addr, got); checks++;
      if ((got & e.mask) !== e.exp) begin
        errors++; $display("FAIL %s: got %h want %h", e.name, got & e.mask, e.exp);
      end
    end
    tick(10);
    checks++;
    if (bus.io_intr !== 1'b0) begin
      errors++; $display("FAIL rst_no_reassert: got %b want 0", bus.io_intr);
    end
  endtask

  initial begin
    bus.io_cs = 1'b0; bus.io_wr = 1'b0; bus.io_rd = 1'b0;
    bus.Address = '0; bus.D_In = '0; bus.intr_ack = 1'b0;
    test_reset();
    test_memory();
    test_oneshot();
    test_periodic();
    test_priority();
    test_reset_midflight();
    checks++;
    if (intr_q.size() != 0) begin
      errors++; $display("FAIL intr_scoreboard_drain: got %0d left want 0", intr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
